spram_mul_sequencer: RTL

Sequencer and port owner for the 128-bit single-port RAM that holds HPS-bridge data. It shares the one RAM port between the h2f host (word reads and writes) and an internal multiply job. Each job streams N words from a source region, multiplies the four adjacent short pairs of every word on registered DSP lanes, and writes the four 32-bit products back to a destination region.

---
 rtl/spram_mul_pkg.sv | 23 ++
 rtl/spram_mul_sequencer_dsp_mul4.sv | 36 +++
 rtl/spram_mul_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spram_mul_pkg.sv
// Shared definitions for the single-port RAM multiply sequencer.
// Covers the lane geometry, the FSM encoding and the lane slice helper.
package spram_mul_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 8;
    localparam int PAIRS  = 4;
    localparam int PROD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_MUL,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic int lane_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/spram_mul_sequencer_dsp_mul4.sv
// Four registered signed 16x16 multipliers with one cycle of latency.
// Adjacent shorts (2k, 2k+1) form pair k, and its 32-bit product lands in lane k.
module dsp_mul4
    import spram_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] operand_p0,
    output logic [DATA_WIDTH-1:0] product_p1
);

    logic signed [LANE_W-1:0] lane_a [PAIRS];
    logic signed [LANE_W-1:0] lane_b [PAIRS];

    always_comb begin
        for (int k = 0; k < PAIRS; k++) begin
            lane_a[k] = operand_p0[lane_off(2*k, LANE_W) +: LANE_W];
            lane_b[k] = operand_p0[lane_off(2*k+1, LANE_W) +: LANE_W];
        end
    end

    // p0 -> p1: full-precision products, 32 bits always holds a 16x16 signed product
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product_p1 <= '0;
        end else if (en) begin
            for (int k = 0; k < PAIRS; k++) begin
                product_p1[lane_off(k, PROD_W) +: PROD_W] <= PROD_W'(lane_a[k]) * PROD_W'(lane_b[k]);
            end
        end
    end

endmodule

// File: rtl/spram_mul_sequencer.sv
// Owns the single RAM port, sharing it between h2f host word accesses and
// a multiply job that rewrites N source words as four 32-bit products each.
module spram_mul_sequencer
    import spram_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_valid,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [ADDR_WIDTH:0]   count_q, idx_q, idx_inc;
    logic [DATA_WIDTH-1:0] operand_p0, product_p1;
    logic                  host_acc, mul_en;

    assign idx_inc    = idx_q + (ADDR_WIDTH+1)'(1);
    assign host_acc   = (state == ST_IDLE) && !start && host_valid;
    assign host_rdata = host_rvalid ? ram_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = (count == '0) ? ST_DONE : ST_RD;
            ST_RD:   state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_MUL;
            ST_MUL:  state_nxt = ST_WR;
            ST_WR:   state_nxt = (idx_inc < count_q) ? ST_RD : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        host_ready = 1'b0;
        ram_addr   = '0;
        ram_data   = '0;
        ram_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mul_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                host_ready = !start;
                if (host_acc) begin
                    ram_addr = host_addr;
                    ram_we   = host_write;
                    if (host_write) ram_data = host_wdata;
                end
            end
            ST_RD: begin
                busy     = 1'b1;
                ram_addr = src_q + idx_q[ADDR_WIDTH-1:0];
            end
            ST_WAIT: busy = 1'b1;
            ST_MUL: begin
                busy   = 1'b1;
                mul_en = 1'b1;
            end
            ST_WR: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = dst_q + idx_q[ADDR_WIDTH-1:0];
                ram_data = product_p1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // RAM -> p0: ram_q holds the RD-cycle word during WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q       <= '0;
            dst_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            operand_p0  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                src_q   <= src_base;
                dst_q   <= dst_base;
                count_q <= count;
                idx_q   <= '0;
            end else if (state == ST_WR) begin
                idx_q <= idx_inc;
            end
            if (state == ST_WAIT) operand_p0 <= ram_q;
            host_rvalid <= host_acc && !host_write;
        end
    end

    dsp_mul4 #(.DATA_WIDTH(DATA_WIDTH)) u_dsp_mul4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (mul_en),
        .operand_p0 (operand_p0),
        .product_p1 (product_p1)
    );

endmodule
